imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer sitting between the PC/branch logic and the program memory.
- Owns the fetch PC and issues one word read per cycle, byte-addressed; the memory drops the low 2 bits.
- Buffers returned words with their PCs in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush plus squash of the in-flight read) and halt.

---
 rtl/mips_fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/imem_fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package mips_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr}; push and pop may coincide at any
// occupancy, and a synchronous clear empties it (clear wins over push/pop).
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  entry_t        data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output entry_t        head_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i & ~clr_i;
  assign do_pop  = pop_i & valid_o & ~clr_i;

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = data_i;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The fetch issue rule reserves a slot per in-flight read, so a full push is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one read per cycle, handles redirect/halt.
// Optional misaligned-redirect trap enabled by defining IMEM_FETCH_ALIGN_CHECK_EN.
module imem_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_rd_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic                  halted_o,
  output logic                  fetch_err_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic                  fifo_valid, pop, push, issue, redirect_act;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occ, lim;
  logic [DATA_WIDTH-1:0] target_pc;
  entry_t                push_entry, head;

`ifdef IMEM_FETCH_ALIGN_CHECK_EN
  logic err_q, err_d, misaligned;
  assign target_pc    = redirect_pc_i;
  assign misaligned   = |redirect_pc_i[1:0];
  assign redirect_act = redirect_i & (state_q != ERR);
  assign err_d        = err_q | (redirect_act & misaligned);
  assign fetch_err_o  = err_q;
`else
  assign target_pc    = redirect_pc_i & ~DATA_WIDTH'(3);
  assign redirect_act = redirect_i;
  assign fetch_err_o  = 1'b0;
`endif

  assign pop = fifo_valid & instr_ready_i;
  // Compare as count+inflight < DEPTH+pop to avoid underflow on the subtraction.
  assign occ   = (CW+1)'(fifo_count) + (CW+1)'(inflight_q);
  assign lim   = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
  assign issue = (state_q == RUN) & ~redirect_i & ~halt_i & (occ < lim);

  // A response landing in the redirect cycle belongs to the old stream: squash it.
  assign push       = inflight_q & ~redirect_act;
  assign push_entry = '{pc: pc_q - DATA_WIDTH'(PC_STEP), instr: mem_rdata_i};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = issue;
    if (issue) pc_d = pc_q + DATA_WIDTH'(PC_STEP);
    if (redirect_act) begin
      pc_d    = target_pc;
      state_d = halt_i ? HALT : RUN;
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
      if (misaligned) state_d = ERR;
`endif
    end else if (halt_i && state_q == RUN) begin
      state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (redirect_act),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop & ~redirect_act),
    .valid_o (fifo_valid),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign mem_rd_o      = issue & reset;
  assign mem_addr_o    = pc_q;
  assign instr_valid_o = fifo_valid;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
  assign halted_o      = (state_q == HALT) & ~inflight_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed stimulus pushes expected PCs,
// a negedge monitor pops and compares on every accepted instruction.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i = 32'hDEAD_BEEF;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        halted_o;
  logic        fetch_err_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_pops   = 0;
  logic [31:0] exp_pc_q [$];
  logic [31:0] sb_e;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .DATA_WIDTH (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_rd_o      (mem_rd_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .halted_o      (halted_o),
    .fetch_err_o   (fetch_err_o)
  );

  // Program memory: one-cycle read latency, word = aligned address ^ KEY.
  always @(posedge clk)
    mem_rdata_i <= mem_rd_o ? ((mem_addr_o & ~32'h3) ^ KEY) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_seq(input logic [31:0] start, input int unsigned n);
    exp_pc_q.delete();
    for (int unsigned i = 0; i < n; i++) exp_pc_q.push_back(start + 4 * i);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset && instr_valid_o && instr_ready_i && !redirect_i) begin
      n_pops++;
      if (exp_pc_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got pc %h expected no instruction", instr_pc_o);
      end else begin
        sb_e = exp_pc_q.pop_front();
        check("sb_pc", instr_pc_o, sb_e);
        check("sb_instr", instr_o, sb_e ^ KEY);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        ok;
    int unsigned reads, pops0;

    reset = 1'b0; instr_ready_i = 1'b1; redirect_i = 1'b0;
    redirect_pc_i = '0; halt_i = 1'b0;
    repeat (2) @(posedge clk);
    neg;
    check("rst_mem_rd", mem_rd_o, 0);
    check("rst_mem_addr", mem_addr_o, RST_PC);
    check("rst_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_instr_pc", instr_pc_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_err", fetch_err_o, 0);

    // Streaming from reset
    load_seq(RST_PC, 64);
    reset = 1'b1;
    #1;
    check("c0_rd", mem_rd_o, 1);
    check("c0_addr", mem_addr_o, RST_PC);
    tick; neg;
    check("c1_addr", mem_addr_o, 32'h0040_0004);
    check("c1_valid", instr_valid_o, 0);
    tick; neg;
    check("c2_valid", instr_valid_o, 1);
    check("c2_pc", instr_pc_o, RST_PC);
    ok = 1'b1;
    repeat (6) begin tick; neg; if (!instr_valid_o || !mem_rd_o) ok = 1'b0; end
    check("stream_rate", ok, 1);

    // Redirect with a read in flight
    tick; redirect_i = 1'b1; redirect_pc_i = 32'h0040_0100; load_seq(32'h0040_0100, 64);
    neg;
    check("redir_no_issue", mem_rd_o, 0);
    tick; redirect_i = 1'b0; neg;
    check("redir_n1_valid", instr_valid_o, 0);
    check("redir_n1_rd", mem_rd_o, 1);
    check("redir_n1_addr", mem_addr_o, 32'h0040_0100);
    tick; neg;
    check("redir_n2_valid", instr_valid_o, 0);
    tick; neg;
    check("redir_n3_valid", instr_valid_o, 1);
    check("redir_n3_pc", instr_pc_o, 32'h0040_0100);
    repeat (3) begin tick; neg; end

    // Backpressure from an empty pipe: exactly two reads fill the FIFO
    tick; redirect_i = 1'b1; redirect_pc_i = 32'h0040_0200; instr_ready_i = 1'b0;
    load_seq(32'h0040_0200, 64);
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      neg;
      if (mem_rd_o) reads++;
      tick;
      redirect_i = 1'b0;
    end
    neg;
    check("stall_reads", reads, 2);
    check("stall_rd_idle", mem_rd_o, 0);
    check("stall_head_valid", instr_valid_o, 1);
    check("stall_head_pc", instr_pc_o, 32'h0040_0200);
    tick; instr_ready_i = 1'b1;
    repeat (6) begin tick; neg; end

    // Halt with two entries buffered and nothing in flight
    tick; instr_ready_i = 1'b0;
    repeat (3) tick;
    tick; halt_i = 1'b1; instr_ready_i = 1'b1; pops0 = n_pops;
    neg;
    check("halt_no_issue", mem_rd_o, 0);
    tick; halt_i = 1'b0; neg;
    check("halt_d1_rd", mem_rd_o, 0);
    check("halt_d1_valid", instr_valid_o, 1);
    check("halted_d1", halted_o, 1);
    tick; neg;
    check("halt_drained_valid", instr_valid_o, 0);
    check("halted_d2", halted_o, 1);
    check("halt_drain_count", n_pops - pops0, 2);
    ok = 1'b1;
    repeat (2) begin tick; neg; if (mem_rd_o || instr_valid_o) ok = 1'b0; end
    check("halt_idle", ok, 1);

    // Resume by redirect
    tick; redirect_i = 1'b1; redirect_pc_i = 32'h0040_0040; load_seq(32'h0040_0040, 64);
    neg;
    check("resume_n_rd", mem_rd_o, 0);
    tick; redirect_i = 1'b0; neg;
    check("resume_rd", mem_rd_o, 1);
    check("resume_addr", mem_addr_o, 32'h0040_0040);
    check("resume_halted", halted_o, 0);
    tick; neg; tick; neg;
    check("resume_valid", instr_valid_o, 1);
    check("resume_pc", instr_pc_o, 32'h0040_0040);
    repeat (3) begin tick; neg; end

    // Misaligned redirect target
    tick; redirect_i = 1'b1; redirect_pc_i = 32'h0040_0102;
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
    exp_pc_q.delete();
`else
    load_seq(32'h0040_0100, 64);
`endif
    tick; redirect_i = 1'b0; neg;
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
    check("mis_err", fetch_err_o, 1);
    check("mis_rd", mem_rd_o, 0);
    check("mis_valid", instr_valid_o, 0);
    ok = 1'b1;
    repeat (4) begin tick; neg; if (mem_rd_o || instr_valid_o || !fetch_err_o) ok = 1'b0; end
    check("mis_hold", ok, 1);
`else
    check("mis_err", fetch_err_o, 0);
    check("mis_addr", mem_addr_o, 32'h0040_0100);
    tick; neg; tick; neg;
    check("mis_valid", instr_valid_o, 1);
    check("mis_pc", instr_pc_o, 32'h0040_0100);
    repeat (3) begin tick; neg; end
`endif

    // Asynchronous reset mid-operation
    tick; #1 reset = 1'b0; #1;
    exp_pc_q.delete();
    check("rst2_rd", mem_rd_o, 0);
    check("rst2_valid", instr_valid_o, 0);
    check("rst2_err", fetch_err_o, 0);
    check("rst2_addr", mem_addr_o, RST_PC);
    check("rst2_halted", halted_o, 0);
    load_seq(RST_PC, 64);
    neg; reset = 1'b1; #1;
    check("rst2_c0_rd", mem_rd_o, 1);
    tick; tick; neg;
    check("rst2_c2_valid", instr_valid_o, 1);
    check("rst2_c2_pc", instr_pc_o, RST_PC);
    repeat (3) begin tick; neg; end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
